// File: rtl/scalar_mult_scheduler_if.sv
// Bundle of request, shared-multiplier and response signals for scalar_mult_scheduler.
// The scheduler takes the slave view; the requesters, multiplier and consumer take the master view.
interface scalar_mult_scheduler_if #(
  parameter int unsigned TOTAL_WIDTH = 32,
  parameter int unsigned VECTOR_SIZE = 8,
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned ID_W        = $clog2(NUM_REQ)
);
  localparam int unsigned VW = TOTAL_WIDTH * VECTOR_SIZE;

  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0]             req_ready;
  logic [NUM_REQ*TOTAL_WIDTH-1:0] req_scalar;
  logic [NUM_REQ*VW-1:0]          req_vector;

  logic [TOTAL_WIDTH-1:0]         mult_scalar;
  logic [VW-1:0]                  mult_in_vector;
  logic [VW-1:0]                  mult_out_vector;

  logic                           rsp_valid;
  logic                           rsp_ready;
  logic [ID_W-1:0]                rsp_id;
  logic [VW-1:0]                  rsp_vector;

  modport slave (
    input  req_valid, req_scalar, req_vector, mult_out_vector, rsp_ready,
    output req_ready, mult_scalar, mult_in_vector, rsp_valid, rsp_id, rsp_vector
  );

  modport master (
    output req_valid, req_scalar, req_vector, mult_out_vector, rsp_ready,
    input  req_ready, mult_scalar, mult_in_vector, rsp_valid, rsp_id, rsp_vector
  );
endinterface

// File: rtl/scalar_mult_scheduler.sv
// Shares one combinational scalar-by-vector multiplier between NUM_REQ requesters (IDLE/CALC/RESP).
// Define SCHED_FIXED_PRIO_EN to replace round-robin arbitration with lowest-index-wins priority.
module scalar_mult_scheduler #(
  parameter int unsigned TOTAL_WIDTH = 32,
  parameter int unsigned VECTOR_SIZE = 8,
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned ID_W        = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  scalar_mult_scheduler_if.slave   bus
);
  localparam int unsigned VW = TOTAL_WIDTH * VECTOR_SIZE;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    RESP
  } state_e;

  state_e state_q, state_d;

  logic [TOTAL_WIDTH-1:0] op_scalar_q, op_scalar_d;
  logic [VW-1:0]          op_vector_q, op_vector_d;
  logic [ID_W-1:0]        id_q, id_d;
  logic [VW-1:0]          rsp_vector_q, rsp_vector_d;
`ifndef SCHED_FIXED_PRIO_EN
  logic [ID_W-1:0]        rr_ptr_q, rr_ptr_d;
`endif

  logic [TOTAL_WIDTH-1:0] scalar_arr [NUM_REQ];
  logic [VW-1:0]          vector_arr [NUM_REQ];
  logic                   grant_found;
  logic [ID_W-1:0]        grant_idx;
  logic [31:0]            scan_idx;
  logic                   grant_fire;

  for (genvar r = 0; r < NUM_REQ; r++) begin : g_unpack
    assign scalar_arr[r] = bus.req_scalar[r*TOTAL_WIDTH +: TOTAL_WIDTH];
    assign vector_arr[r] = bus.req_vector[r*VW +: VW];
  end

  // Scan all requesters once, starting at the rotation pointer and wrapping at NUM_REQ.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
`ifdef SCHED_FIXED_PRIO_EN
      scan_idx = i;
`else
      scan_idx = 32'(rr_ptr_q) + i;
      if (scan_idx >= NUM_REQ) scan_idx = scan_idx - NUM_REQ;
`endif
      if (!grant_found && bus.req_valid[ID_W'(scan_idx)]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(scan_idx);
      end
    end
  end

  // Reset gating keeps req_ready low while rst_n is asserted, even in IDLE.
  assign grant_fire = rst_n && (state_q == IDLE) && grant_found;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (grant_found) state_d = CALC;
      CALC:    state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = '0;
    if (grant_fire) bus.req_ready[grant_idx] = 1'b1;
    bus.rsp_valid = (state_q == RESP);
  end

  always_comb begin
    op_scalar_d  = op_scalar_q;
    op_vector_d  = op_vector_q;
    id_d         = id_q;
    rsp_vector_d = rsp_vector_q;
`ifndef SCHED_FIXED_PRIO_EN
    rr_ptr_d     = rr_ptr_q;
`endif
    if (grant_fire) begin
      op_scalar_d = scalar_arr[grant_idx];
      op_vector_d = vector_arr[grant_idx];
      id_d        = grant_idx;
`ifndef SCHED_FIXED_PRIO_EN
      rr_ptr_d    = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
`endif
    end
    if (state_q == CALC) rsp_vector_d = bus.mult_out_vector;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_scalar_q  <= '0;
      op_vector_q  <= '0;
      id_q         <= '0;
      rsp_vector_q <= '0;
`ifndef SCHED_FIXED_PRIO_EN
      rr_ptr_q     <= '0;
`endif
    end else begin
      op_scalar_q  <= op_scalar_d;
      op_vector_q  <= op_vector_d;
      id_q         <= id_d;
      rsp_vector_q <= rsp_vector_d;
`ifndef SCHED_FIXED_PRIO_EN
      rr_ptr_q     <= rr_ptr_d;
`endif
    end
  end

  assign bus.mult_scalar    = op_scalar_q;
  assign bus.mult_in_vector = op_vector_q;
  assign bus.rsp_id         = id_q;
  assign bus.rsp_vector     = rsp_vector_q;
endmodule

// File: tb/tb_scalar_mult_scheduler.sv
// Scoreboard bench for scalar_mult_scheduler: directed requests push expected grants/responses,
// negedge monitors pop and compare; the shared multiplier is modelled combinationally here.
module tb_scalar_mult_scheduler;
  localparam int unsigned TW  = 32;
  localparam int unsigned VS  = 8;
  localparam int unsigned NR  = 4;
  localparam int unsigned IDW = 2;
  localparam int unsigned VW  = TW * VS;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  scalar_mult_scheduler_if #(.TOTAL_WIDTH(TW), .VECTOR_SIZE(VS), .NUM_REQ(NR), .ID_W(IDW)) bus ();

  scalar_mult_scheduler #(.TOTAL_WIDTH(TW), .VECTOR_SIZE(VS), .NUM_REQ(NR), .ID_W(IDW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  for (genvar e = 0; e < VS; e++) begin : g_mult
    assign bus.mult_out_vector[e*TW +: TW] = bus.mult_scalar * bus.mult_in_vector[e*TW +: TW];
  end

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [VW-1:0]  v;
  } rsp_t;

  rsp_t        exp_rsp[$];
  int unsigned exp_grant[$];
  int unsigned pend[NR];
  int unsigned grants;
  int          n_cmp = 0;
  int          n_err = 0;
  int unsigned mon_g;
  rsp_t        mon_r;
  logic [NR-1:0] rdy;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [VW-1:0] vec_seq(input logic [31:0] m);
    logic [VW-1:0] v;
    for (int e = 0; e < VS; e++) v[e*TW +: TW] = m * 32'(e + 1);
    return v;
  endfunction

  function automatic logic [VW-1:0] vec_fill(input logic [31:0] x);
    logic [VW-1:0] v;
    for (int e = 0; e < VS; e++) v[e*TW +: TW] = x;
    return v;
  endfunction

  task automatic set_req(input int r, input logic [31:0] sc, input logic [VW-1:0] vec, input int unsigned n);
    bus.req_scalar[r*TW +: TW] = sc;
    bus.req_vector[r*VW +: VW] = vec;
    pend[r] = n;
    bus.req_valid[r] = 1'b1;
  endtask

  task automatic push_exp(input int unsigned id, input logic [VW-1:0] v);
    rsp_t t;
    t.id = IDW'(id);
    t.v  = v;
    exp_grant.push_back(id);
    exp_rsp.push_back(t);
  endtask

  // One clock: sample grants mid-cycle, then retire the requesters that were accepted.
  task automatic cycle(output logic [NR-1:0] r_o);
    @(negedge clk);
    r_o = bus.req_ready;
    @(posedge clk);
    #1;
    for (int r = 0; r < NR; r++) begin
      if (r_o[r]) begin
        grants++;
        if (pend[r] > 0) pend[r]--;
        if (pend[r] == 0) bus.req_valid[r] = 1'b0;
      end
    end
  endtask

  task automatic drain(input string nm);
    logic [NR-1:0] r;
    int n = 0;
    while (exp_rsp.size() != 0 && n < 80) begin
      cycle(r);
      n++;
    end
    n_cmp++;
    if (exp_rsp.size() != 0) begin
      n_err++;
      $display("FAIL %s_timeout: got %0d pending responses expected 0", nm, exp_rsp.size());
    end
  endtask

  always @(negedge clk) begin
    if (bus.req_ready != '0) begin
      if (exp_grant.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL grant_unexpected: got req_ready=%b expected none", bus.req_ready);
      end else begin
        mon_g = exp_grant.pop_front();
        chk("grant", 256'(bus.req_ready), 256'(1) << mon_g);
      end
    end
    if (bus.rsp_valid && bus.rsp_ready) begin
      if (exp_rsp.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL rsp_unexpected: got id=%0d vector=%h expected none", bus.rsp_id, bus.rsp_vector);
      end else begin
        mon_r = exp_rsp.pop_front();
        chk("rsp_id", 256'(bus.rsp_id), 256'(mon_r.id));
        chk("rsp_vector", bus.rsp_vector, mon_r.v);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n          = 1'b0;
    bus.req_valid  = '1;
    bus.req_scalar = '0;
    bus.req_vector = '0;
    bus.rsp_ready  = 1'b1;
    for (int r = 0; r < NR; r++) pend[r] = 0;
    grants = 0;

    // Reset state, with requests present while in reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_req_ready", 256'(bus.req_ready), 256'(0));
    chk("reset_rsp_valid", 256'(bus.rsp_valid), 256'(0));
    chk("reset_rsp_id", 256'(bus.rsp_id), 256'(0));
    chk("reset_rsp_vector", bus.rsp_vector, 256'(0));
    chk("reset_mult_scalar", 256'(bus.mult_scalar), 256'(0));
    chk("reset_mult_in_vector", bus.mult_in_vector, 256'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.req_valid = '0;

    // Single request with latency checks
    set_req(1, 32'd3, vec_seq(1), 1);
    push_exp(1, vec_seq(3));
    cycle(rdy);
    chk("single_grant_cycle", 256'(rdy), 256'(4'b0010));
    @(negedge clk);
    chk("single_t1_mult_scalar", 256'(bus.mult_scalar), 256'(32'd3));
    chk("single_t1_mult_in_vector", bus.mult_in_vector, vec_seq(1));
    chk("single_t1_rsp_valid", 256'(bus.rsp_valid), 256'(0));
    chk("single_t1_req_ready", 256'(bus.req_ready), 256'(0));
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("single_t2_rsp_valid", 256'(bus.rsp_valid), 256'(1));
    @(posedge clk);
    #1;

    // Signed wrap: -2 * 5 = -10
    set_req(2, 32'hFFFF_FFFE, vec_fill(32'd5), 1);
    push_exp(2, vec_fill(32'hFFFF_FFF6));
    drain("signed");

    // Contention from reset with all four requesters
    rst_n = 1'b0;
    for (int r = 0; r < NR; r++) set_req(r, 32'(r + 2), vec_seq(1), 100);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
`ifdef SCHED_FIXED_PRIO_EN
    for (int k = 0; k < 5; k++) push_exp(0, vec_seq(2));
`else
    push_exp(0, vec_seq(2));
    push_exp(1, vec_seq(3));
    push_exp(2, vec_seq(4));
    push_exp(3, vec_seq(5));
    push_exp(0, vec_seq(2));
`endif
    grants = 0;
    for (int n = 0; n < 100 && grants < 5; n++) cycle(rdy);
    bus.req_valid = '0;
    for (int r = 0; r < NR; r++) pend[r] = 0;
    chk("contention_grant_count", 256'(grants), 256'(5));
    drain("contention");

    // Back-pressure: hold the response for 10 cycles with another request waiting
    bus.rsp_ready = 1'b0;
    set_req(1, 32'd7, vec_seq(1), 1);
    set_req(3, 32'd2, vec_seq(1), 1);
    push_exp(1, vec_seq(7));
    push_exp(3, vec_seq(2));
    cycle(rdy);
    cycle(rdy);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp_rsp_valid", 256'(bus.rsp_valid), 256'(1));
      chk("bp_rsp_id", 256'(bus.rsp_id), 256'(1));
      chk("bp_rsp_vector", bus.rsp_vector, vec_seq(7));
      chk("bp_req_ready", 256'(bus.req_ready), 256'(0));
      @(posedge clk);
      #1;
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_req_ready", 256'(bus.req_ready), 256'(0));
    @(posedge clk);
    #1;
    cycle(rdy);
    chk("bp_next_grant", 256'(rdy), 256'(4'b1000));
    drain("backpressure");

    // Mid-operation reset in CALC; in-flight result discarded, pointer back to 0
    set_req(2, 32'd9, vec_seq(1), 1);
    exp_grant.push_back(2);
    cycle(rdy);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_req_ready", 256'(bus.req_ready), 256'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_rsp_valid", 256'(bus.rsp_valid), 256'(0));
    chk("midrst_mult_scalar", 256'(bus.mult_scalar), 256'(0));
    chk("midrst_mult_in_vector", bus.mult_in_vector, 256'(0));
    chk("midrst_rsp_vector", bus.rsp_vector, 256'(0));
    @(posedge clk);
    #1;
    set_req(1, 32'd4, vec_seq(1), 1);
    set_req(3, 32'd5, vec_seq(1), 1);
    push_exp(1, vec_seq(4));
    push_exp(3, vec_seq(5));
    drain("midreset");

    // Withdrawn request: 2 drops out before its turn
    set_req(0, 32'd6, vec_seq(1), 2);
    set_req(2, 32'd13, vec_seq(1), 1);
    set_req(3, 32'd11, vec_seq(1), 1);
`ifdef SCHED_FIXED_PRIO_EN
    push_exp(0, vec_seq(6));
    push_exp(0, vec_seq(6));
    push_exp(3, vec_seq(11));
`else
    push_exp(0, vec_seq(6));
    push_exp(3, vec_seq(11));
    push_exp(0, vec_seq(6));
`endif
    cycle(rdy);
    bus.req_valid[2] = 1'b0;
    pend[2] = 0;
    drain("withdrawn");

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("grant_queue_empty", 256'(exp_grant.size()), 256'(0));
    chk("rsp_queue_empty", 256'(exp_rsp.size()), 256'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/scalar_mult_scheduler.md
# scalar_mult_scheduler

Round-robin scheduler that shares one `scalar_multiplier_v_area` instance (combinational, TOTAL_WIDTH×VECTOR_SIZE) between NUM_REQ requesters, such as per-layer alpha-scaling engines in the XNOR/binary-connect datapath.
- Per request: accepts one scalar and one vector through a valid/ready handshake.
- Registers the operands in front of the shared multiplier and registers the product vector behind it.
- Returns the result tagged with the requester index on a single response channel.

## Interface
- TOTAL_WIDTH, 32, element and scalar width (signed two's complement)
- VECTOR_SIZE, 8, elements per vector
- NUM_REQ, 4, number of requesters (2..16)
- ID_W, $clog2(NUM_REQ), width of rsp_id

- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  NUM_REQ  bit r: requester r has an operand pair
- req_ready  out  NUM_REQ  bit r: operands of r accepted this cycle (one-hot or zero)
- req_scalar  in  NUM_REQ*TOTAL_WIDTH  requester r at [r*TOTAL_WIDTH +: TOTAL_WIDTH]
- req_vector  in  NUM_REQ*TOTAL_WIDTH*VECTOR_SIZE  requester r at [r*TOTAL_WIDTH*VECTOR_SIZE +: TOTAL_WIDTH*VECTOR_SIZE]
- mult_scalar  out  TOTAL_WIDTH  to shared multiplier `scalar`
- mult_in_vector  out  TOTAL_WIDTH*VECTOR_SIZE  to shared multiplier `in_vector`
- mult_out_vector  in  TOTAL_WIDTH*VECTOR_SIZE  from shared multiplier `out_vector` (low TOTAL_WIDTH bits of each product)
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  ID_W  requester index of the result
- rsp_vector  out  TOTAL_WIDTH*VECTOR_SIZE  registered product vector

## Operation
- FSM states: IDLE, CALC, RESP. Reset state is IDLE.
- **IDLE**
  - If any req_valid bit is set, select winner g by round-robin, searching upward from rr_ptr with wrap at NUM_REQ.
  - Assert req_ready[g] combinationally in that same cycle.
  - Latch req_scalar[g] and req_vector[g] into the operand registers; latch g into the id register.
  - Update rr_ptr to (g+1) mod NUM_REQ; go to CALC.
  - If no req_valid bit is set, stay in IDLE with req_ready = 0.
- **CALC**
  - mult_scalar and mult_in_vector are driven from the operand registers (always, in every state).
  - Capture mult_out_vector into the rsp_vector register; go to RESP.
- **RESP**
  - rsp_valid = 1; rsp_id and rsp_vector are stable.
  - When rsp_ready = 1, the transfer completes and the FSM goes to IDLE. Otherwise it holds.
- req_ready is 0 in CALC and RESP; requests keep req_valid asserted until they see req_ready.
- No arithmetic in this block. Products wrap to the low TOTAL_WIDTH bits, as defined by the multiplier.
- A requester that deasserts req_valid before it is granted is simply skipped. It does not move rr_ptr.

## Timing
- Reset values:
  - req_ready = 0, rsp_valid = 0, rsp_id = 0, rsp_vector = 0.
  - mult_scalar = 0, mult_in_vector = 0, rr_ptr = 0, state = IDLE.
- Latency: grant at cycle T; operands are visible on the mult_* ports at T+1; rsp_valid rises at T+2.
- Throughput: one operation per 3 cycles when rsp_ready is held at 1.
- Back-pressure: the FSM stays in RESP indefinitely and accepts no new request until the response is taken.
- Simultaneous requests: exactly one grant per IDLE cycle. Losers wait and are served in rotation, so worst-case wait is NUM_REQ operations.
- Reset mid-operation (rst_n low in CALC or RESP):
  - Next cycle is IDLE; rsp_valid = 0; the in-flight result is discarded.
  - rr_ptr = 0; no req_ready is asserted while rst_n is low.

## Configuration
- `SCHED_FIXED_PRIO_EN`
  - Defined: round-robin is replaced by fixed priority, where the lowest index with req_valid wins. rr_ptr is not implemented.
  - Undefined (default): round-robin as specified above.

## Test plan
- Single request: req 1 with scalar 3 and vector {1,2,...,8} → req_ready[1] for one cycle; two cycles later rsp_valid = 1, rsp_id = 1, rsp_vector = {3,6,...,24}.
- Signed wrap: scalar 0xFFFFFFFE (−2) and all elements 5 → every rsp element = 0xFFFFFFF6.
- Contention: all four requesters valid continuously from reset → grant order 0,1,2,3,0. With `SCHED_FIXED_PRIO_EN` defined → grant order 0,0,0…
- Back-pressure: rsp_ready held 0 for 10 cycles → rsp_valid, rsp_id and rsp_vector stay stable. req_ready stays 0 until one cycle after rsp_ready goes to 1.
- Mid-operation reset: rst_n pulled low for one cycle in CALC → next cycle is IDLE, rsp_valid = 0, mult_scalar = 0. The next grant goes to the lowest valid index.
- Withdrawn request: req 2 drops req_valid before its turn while reqs 0 and 3 are active → grant order 0,3,0 with no response carrying id 2.
